// File: rtl/switch_bounce_gen.sv
// Contact-bounce emulator: turns a clean switch level into a bouncy one
// for exercising debounce logic in simulation and on the board.
module switch_bounce_gen #(
    parameter int          c_BOUNCE_LIMIT = 250000,
    parameter int          c_MIN_HOLD     = 1000,
    parameter int          c_JITTER_BITS  = 8,
    parameter logic [15:0] c_SEED         = 16'hACE1
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Switch,
    output logic o_Switch,
    output logic o_Busy
);

    // An all-zero LFSR would never leave zero, so a zero seed is replaced.
    localparam logic [15:0] SEED =
        (c_SEED == 16'h0000) ? 16'hACE1 : c_SEED;
    localparam logic [17:0] WIN_LAST = 18'(c_BOUNCE_LIMIT - 1);
    localparam logic [15:0] HOLD_MIN = 16'(c_MIN_HOLD);

    typedef enum logic {
        IDLE,
        BOUNCE
    } state_t;

    state_t      state_q, state_d;
    logic        level_q, level_d;
    logic        sw_q, sw_d;
    logic        busy_q, busy_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [17:0] win_q, win_d;
    logic [15:0] hold_q, hold_d;
    logic [15:0] len_q, len_d;

    logic        fb;
    logic        retrig;
    logic [15:0] new_len;

    assign fb      = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign retrig  = (i_Switch != level_q);
    assign new_len = HOLD_MIN + 16'(lfsr_q[c_JITTER_BITS-1:0]);

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        sw_d    = sw_q;
        busy_d  = busy_q;
        lfsr_d  = {lfsr_q[14:0], fb};
        win_d   = win_q;
        hold_d  = hold_q;
        len_d   = len_q;

        unique case (state_q)
            IDLE: begin
                sw_d   = level_q;
                busy_d = 1'b0;
            end
            BOUNCE: begin
                win_d = win_q + 18'd1;
                if (win_q == WIN_LAST) begin
                    sw_d    = level_q;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (hold_q == len_q - 16'd1) begin
                    sw_d   = ~sw_q;
                    hold_d = 16'd0;
                    len_d  = new_len;
                end else begin
                    hold_d = hold_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new target level restarts the window from either state.
        if (retrig) begin
            level_d = i_Switch;
            sw_d    = i_Switch;
            win_d   = 18'd0;
            hold_d  = 16'd0;
            len_d   = new_len;
            busy_d  = 1'b1;
            state_d = BOUNCE;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q <= IDLE;
            level_q <= 1'b0;
            sw_q    <= 1'b0;
            busy_q  <= 1'b0;
            lfsr_q  <= SEED;
            win_q   <= 18'd0;
            hold_q  <= 16'd0;
            len_q   <= HOLD_MIN;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            sw_q    <= sw_d;
            busy_q  <= busy_d;
            lfsr_q  <= lfsr_d;
            win_q   <= win_d;
            hold_q  <= hold_d;
            len_q   <= len_d;
        end
    end

    assign o_Switch = sw_q;
    assign o_Busy   = busy_q;

endmodule

// File: tb/tb_switch_bounce_gen.sv
// Directed bench for switch_bounce_gen: cycle model feeds a scoreboard,
// plus window/toggle/debouncer properties checked over each scenario.
module tb_switch_bounce_gen;

    localparam int LIMIT = 64;
    localparam int MINH  = 4;
    localparam int JB    = 2;

    logic clk = 1'b0;
    logic i_Rst;
    logic i_Switch;
    logic sw_m, busy_m, sw_z, busy_z;
    logic sw_a, busy_a, sw_b, busy_b;

    always #5 clk = ~clk;

    switch_bounce_gen #(
        .c_BOUNCE_LIMIT(LIMIT), .c_MIN_HOLD(MINH),
        .c_JITTER_BITS(JB), .c_SEED(16'hACE1)
    ) dut (
        .i_Clk(clk), .i_Rst(i_Rst), .i_Switch(i_Switch),
        .o_Switch(sw_m), .o_Busy(busy_m)
    );

    switch_bounce_gen #(
        .c_BOUNCE_LIMIT(LIMIT), .c_MIN_HOLD(MINH),
        .c_JITTER_BITS(JB), .c_SEED(16'h0000)
    ) dut_z (
        .i_Clk(clk), .i_Rst(i_Rst), .i_Switch(i_Switch),
        .o_Switch(sw_z), .o_Busy(busy_z)
    );

    switch_bounce_gen #(
        .c_BOUNCE_LIMIT(LIMIT), .c_MIN_HOLD(MINH),
        .c_JITTER_BITS(JB), .c_SEED(16'h1234)
    ) dut_a (
        .i_Clk(clk), .i_Rst(i_Rst), .i_Switch(i_Switch),
        .o_Switch(sw_a), .o_Busy(busy_a)
    );

    switch_bounce_gen #(
        .c_BOUNCE_LIMIT(LIMIT), .c_MIN_HOLD(MINH),
        .c_JITTER_BITS(JB), .c_SEED(16'h1234)
    ) dut_b (
        .i_Clk(clk), .i_Rst(i_Rst), .i_Switch(i_Switch),
        .o_Switch(sw_b), .o_Busy(busy_b)
    );

    // Downstream debouncer with a 100-cycle stable requirement.
    logic db_q   = 1'b0;
    int   db_cnt = 0;
    int   db_tr  = 0;
    always @(posedge clk) begin
        if (sw_m !== db_q) begin
            if (db_cnt == 99) begin
                db_q   <= sw_m;
                db_cnt <= 0;
                db_tr  <= db_tr + 1;
            end else begin
                db_cnt <= db_cnt + 1;
            end
        end else begin
            db_cnt <= 0;
        end
    end

    // Model tracks absolute deadlines instead of running counters.
    typedef struct {
        logic        lvl;
        logic        sw;
        logic        busy;
        logic        inb;
        logic [15:0] lfsr;
        int          t;
        int          t_end;
        int          t_tog;
    } mdl_t;

    typedef struct {
        logic sw;
        logic busy;
        logic ssw;
        logic sbusy;
    } exp_t;

    function automatic mdl_t step(input mdl_t m, input logic [15:0] seed,
                                  input logic rst, input logic sin);
        int   jit;
        logic f;
        if (rst) begin
            m.sw   = 1'b0;
            m.busy = 1'b0;
            m.lvl  = 1'b0;
            m.inb  = 1'b0;
            m.lfsr = seed;
        end else begin
            jit    = int'(m.lfsr % 16'd4);
            f      = m.lfsr[15] ^ m.lfsr[13] ^ m.lfsr[12] ^ m.lfsr[10];
            m.lfsr = {m.lfsr[14:0], f};
            if (sin != m.lvl) begin
                m.lvl   = sin;
                m.sw    = sin;
                m.busy  = 1'b1;
                m.inb   = 1'b1;
                m.t_end = m.t + LIMIT;
                m.t_tog = m.t + MINH + jit;
            end else if (m.inb) begin
                if (m.t == m.t_end) begin
                    m.sw   = m.lvl;
                    m.busy = 1'b0;
                    m.inb  = 1'b0;
                end else if (m.t == m.t_tog) begin
                    m.sw    = ~m.sw;
                    m.t_tog = m.t + MINH + jit;
                end
            end
        end
        m.t = m.t + 1;
        return m;
    endfunction

    mdl_t m_a = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 0, 0, 0};
    mdl_t m_s = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 0, 0, 0};
    exp_t sb[$];

    int   n_assert = 0;
    int   n_fail   = 0;
    int   t_now    = 0;
    int   last_t   = 0;
    int   ntog, min_iv, max_iv, busy_cnt, idle_chg;
    logic prev_sw  = 1'b0;
    logic prev_bsy = 1'b0;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        ntog     = 0;
        min_iv   = 1000;
        max_iv   = 0;
        busy_cnt = 0;
        idle_chg = 0;
    endtask

    task automatic cyc(input logic rst, input logic sw);
        exp_t e;
        int   iv;
        i_Rst    = rst;
        i_Switch = sw;
        m_a      = step(m_a, 16'hACE1, rst, sw);
        m_s      = step(m_s, 16'h1234, rst, sw);
        e.sw     = m_a.sw;
        e.busy   = m_a.busy;
        e.ssw    = m_s.sw;
        e.sbusy  = m_s.busy;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("o_Switch", sw_m, e.sw);
        chk("o_Busy", busy_m, e.busy);
        chk("seed0_sw", sw_z, e.sw);
        chk("seed0_busy", busy_z, e.busy);
        chk("seedA_sw", sw_a, e.ssw);
        chk("seedA_busy", busy_a, e.sbusy);
        chk("seedB_sw", sw_b, e.ssw);
        chk("seedB_busy", busy_b, e.sbusy);
        if (sw_m !== prev_sw) begin
            if (prev_bsy && busy_m) begin
                iv = t_now - last_t;
                ntog++;
                if (iv < min_iv) min_iv = iv;
                if (iv > max_iv) max_iv = iv;
                last_t = t_now;
            end else if (!prev_bsy && !busy_m) begin
                idle_chg++;
            end else begin
                last_t = t_now;
            end
        end
        if (busy_m === 1'b1) busy_cnt++;
        prev_sw  = sw_m;
        prev_bsy = busy_m;
        t_now++;
    endtask

    task automatic run(input int n, input logic rst, input logic sw);
        for (int i = 0; i < n; i++) cyc(rst, sw);
    endtask

    int snap;

    initial begin
        i_Rst    = 1'b1;
        i_Switch = 1'b1;
        clear_stats();

        // Reset held with the switch high, then released.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1);
            chk("rst_sw", sw_m, 1'b0);
            chk("rst_busy", busy_m, 1'b0);
        end
        cyc(1'b0, 1'b1);
        chk("rel_sw", sw_m, 1'b1);
        chk("rel_busy", busy_m, 1'b1);
        run(70, 1'b0, 1'b1);
        run(300, 1'b0, 1'b0);

        // Single rise.
        clear_stats();
        snap = db_tr;
        cyc(1'b0, 1'b1);
        chk("rise_lat", sw_m, 1'b1);
        run(LIMIT + 240, 1'b0, 1'b1);
        chk_i("rise_busy_len", busy_cnt, LIMIT);
        chk_i("rise_toggled", int'(ntog > 0), 1);
        chk_i("rise_min_iv_ok", int'(min_iv >= MINH), 1);
        chk_i("rise_max_iv_ok", int'(max_iv <= MINH + 3), 1);
        chk_i("rise_idle_chg", idle_chg, 0);
        chk("rise_final", sw_m, 1'b1);
        chk_i("db_rise_trans", db_tr - snap, 1);
        chk("db_rise_level", db_q, 1'b1);

        // Single fall.
        clear_stats();
        snap = db_tr;
        cyc(1'b0, 1'b0);
        chk("fall_lat", sw_m, 1'b0);
        run(300, 1'b0, 1'b0);
        chk_i("fall_busy_len", busy_cnt, LIMIT);
        chk_i("fall_idle_chg", idle_chg, 0);
        chk_i("db_fall_trans", db_tr - snap, 1);
        chk("db_fall_level", db_q, 1'b0);

        // Rise, then fall at window cycle 20.
        cyc(1'b0, 1'b1);
        run(20, 1'b0, 1'b1);
        clear_stats();
        cyc(1'b0, 1'b0);
        chk("retrig_sw", sw_m, 1'b0);
        chk("retrig_busy", busy_m, 1'b1);
        run(100, 1'b0, 1'b0);
        chk_i("retrig_busy_len", busy_cnt, LIMIT);
        chk("retrig_final", sw_m, 1'b0);

        // Reset in the middle of a window.
        cyc(1'b0, 1'b1);
        run(29, 1'b0, 1'b1);
        cyc(1'b1, 1'b0);
        chk("midrst_sw", sw_m, 1'b0);
        chk("midrst_busy", busy_m, 1'b0);
        clear_stats();
        run(100, 1'b0, 1'b0);
        chk_i("midrst_busy_cnt", busy_cnt, 0);
        chk_i("midrst_idle_chg", idle_chg, 0);
        chk("midrst_final", sw_m, 1'b0);

        chk_i("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/switch_bounce_gen.md
SWITCH_BOUNCE_GEN -- requirements
Module: switch_bounce_gen

Synthesizable contact-bounce emulator: converts a clean switch level into a mechanically bouncy level for exercising debounce logic in simulation and on the board.

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter c_BOUNCE_LIMIT, default 250000: length of the bounce window in clock cycles, range 2..2^18.
REQ-003 Parameter c_MIN_HOLD, default 1000: minimum cycles between output toggles, range 1..2^15.
REQ-004 Parameter c_JITTER_BITS, default 8: number of LFSR bits added to c_MIN_HOLD, range 1..14.
REQ-005 Parameter c_SEED, default 16'hACE1: LFSR reset value.
REQ-006 i_Clk  input  1  system clock, 25 MHz.
REQ-007 i_Rst  input  1  synchronous active-high reset.
REQ-008 i_Switch  input  1  clean target level, synchronous to i_Clk.
REQ-009 o_Switch  output  1  emulated bouncy switch level.
REQ-010 o_Busy  output  1  high while the bounce window is active.

Function
REQ-011 The block SHALL hold r_Level (last accepted target), a 16-bit LFSR, an 18-bit window counter, a 16-bit hold counter, a 16-bit hold length, and a state in {IDLE, BOUNCE}.
REQ-012 The LFSR SHALL advance every non-reset cycle using taps x^16+x^14+x^13+x^11+1 (Fibonacci, shift left, feedback into bit 0).
REQ-013 A c_SEED of 0 SHALL be replaced by 16'hACE1 so the LFSR never locks up.
REQ-014 Hold length SHALL be c_MIN_HOLD + LFSR[c_JITTER_BITS-1:0], sampled from the current LFSR value whenever it is loaded.
REQ-015 IDLE: o_Switch SHALL equal r_Level and o_Busy SHALL be 0.
REQ-016 IDLE, on an edge where i_Switch != r_Level: r_Level <= i_Switch, o_Switch <= i_Switch, window counter <= 0, hold counter <= 0, hold length loaded, o_Busy <= 1, state <= BOUNCE.
REQ-017 Latency SHALL be one cycle: o_Switch reflects a new i_Switch level after the first rising edge at which the change is sampled.
REQ-018 BOUNCE SHALL increment the window counter every cycle.
REQ-019 BOUNCE, when the window counter equals c_BOUNCE_LIMIT-1: o_Switch <= r_Level, o_Busy <= 0, state <= IDLE. No toggle SHALL occur on that edge.
REQ-020 BOUNCE, otherwise, when the hold counter equals hold length-1: o_Switch SHALL invert, the hold counter SHALL clear, and the hold length SHALL reload. Otherwise the hold counter increments.
REQ-021 BOUNCE, on an edge where i_Switch != r_Level, the step in REQ-016 SHALL apply instead (retrigger). Retrigger takes priority over window end and over toggling.
REQ-022 o_Busy SHALL therefore be high for exactly c_BOUNCE_LIMIT consecutive cycles after the last accepted input change.
REQ-023 Toggle spacing within a window SHALL lie in [c_MIN_HOLD, c_MIN_HOLD + 2^c_JITTER_BITS - 1] cycles.
REQ-024 After the window, o_Switch SHALL stay equal to r_Level until i_Switch changes.
REQ-025 The output sequence SHALL be fully deterministic for a given seed and stimulus.

Reset
REQ-026 While i_Rst is high at a rising edge, the block SHALL set o_Switch=0, o_Busy=0, r_Level=0, state=IDLE, all counters=0, hold length=c_MIN_HOLD, and LFSR=c_SEED (or 16'hACE1 per REQ-013).
REQ-027 Reset SHALL override every other event, including mid-window and retrigger.
REQ-028 If i_Switch=1 when reset is released, REQ-016 SHALL apply on the first edge after release.

Verification (bench parameters: c_BOUNCE_LIMIT=64, c_MIN_HOLD=4, c_JITTER_BITS=2)
REQ-029 Reset for 3 cycles with i_Switch=1 -> o_Switch=0 and o_Busy=0 throughout reset; on the first edge after release o_Switch=1 and o_Busy=1.
REQ-030 Single rise 0->1 -> o_Switch=1 one cycle later; o_Busy high exactly 64 cycles; every toggle interval in [4,7]; o_Switch=1 when o_Busy falls and stable for 200 further cycles.
REQ-031 Rise, then fall at window cycle 20 -> o_Switch=0 on the next edge; o_Busy stays high and falls 64 cycles after the fall; final o_Switch=0.
REQ-032 i_Rst asserted at window cycle 30 -> o_Switch=0 and o_Busy=0 on that edge; with i_Switch held 0 the block remains in IDLE with no toggles.
REQ-033 Output fed to a downstream debouncer with a 100-cycle stable limit -> the debouncer output shows exactly one clean transition per i_Switch change, with no glitch.
REQ-034 Two runs with c_SEED=16'h1234 give identical o_Switch traces; c_SEED=0 gives a trace identical to c_SEED=16'hACE1.
